// File: rtl/mem2p_fifo_ctrl.sv
// rtl/mem2p_fifo_ctrl.sv - valid/ready FIFO controller over a two-port memory, 2-entry output skid; optional light sleep via MEM2P_FIFO_LS_EN
module mem2p_fifo_ctrl #(
  parameter int AW       = 5,
  parameter int DW       = 8,
  parameter int IDLE_CYC = 16,
  parameter int WAKE_CYC = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_vld,
  input  logic [DW-1:0] in_dat,
  output logic          in_rdy,
  output logic          out_vld,
  output logic [DW-1:0] out_dat,
  input  logic          out_rdy,
  output logic [AW+1:0] level,
  output logic          mem_mea,
  output logic          mem_rwa,
  output logic [AW-1:0] mem_wadra,
  output logic [DW-1:0] mem_da,
  output logic [DW-1:0] mem_wma,
  output logic          mem_meb,
  output logic [AW-1:0] mem_radrb,
  input  logic [DW-1:0] mem_qb,
  output logic [AW-1:0] mem_radra,
  output logic [AW-1:0] mem_wadrb,
  output logic [DW-1:0] mem_db,
  output logic          mem_rwb,
  output logic [DW-1:0] mem_wmb,
  output logic          mem_ls,
  output logic          mem_ds,
  output logic          mem_sd
);

  localparam int          NW_INT = 1 << AW;
  localparam logic [AW:0] NW     = NW_INT[AW:0];

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_SLEEP  = 2'd1,
    ST_WAKE   = 2'd2
  } state_t;

  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   mcnt;
  logic          inf;
  logic [DW-1:0] sk0;
  logic [DW-1:0] sk1;
  logic [1:0]    skc;

  logic          active;
  logic          wr;
  logic          pop;
  logic [1:0]    skc_pop;
  logic          iss_ok;
  logic          iss;

  // Skid occupancy after this cycle's pop, plus the word returning this
  // cycle, must leave room for one more read so a read in flight always
  // lands in a free slot.
  assign pop     = out_vld & out_rdy;
  assign skc_pop = skc - {1'b0, pop};
  assign iss_ok  = (mcnt != '0) & (({1'b0, skc_pop} + {2'b00, inf}) < 3'd2);

`ifdef MEM2P_FIFO_LS_EN
  localparam int IW = $clog2(IDLE_CYC + 1);
  localparam int WW = $clog2(WAKE_CYC + 1);

  state_t        state;
  state_t        state_nx;
  logic [IW-1:0] idle_cnt;
  logic [WW-1:0] wake_cnt;
  logic          idle;

  assign idle = ~wr & ~iss_ok;

  // State register plus idle and wake dwell counters; flush forces ACTIVE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_ACTIVE;
      idle_cnt <= '0;
      wake_cnt <= '0;
    end else if (flush) begin
      state    <= ST_ACTIVE;
      idle_cnt <= '0;
      wake_cnt <= '0;
    end else begin
      state    <= state_nx;
      idle_cnt <= (state == ST_ACTIVE && idle) ? idle_cnt + 1'b1 : '0;
      wake_cnt <= (state == ST_WAKE) ? wake_cnt + 1'b1 : '0;
    end
  end

  // Next-state: sleep after a run of idle cycles, wake on demand, then
  // hold off memory traffic until the array has left light sleep.
  always_comb begin
    state_nx = state;
    case (state)
      ST_ACTIVE: if (idle && idle_cnt == IW'(IDLE_CYC - 1)) state_nx = ST_SLEEP;
      ST_SLEEP:  if (in_vld || iss_ok) state_nx = ST_WAKE;
      ST_WAKE:   if (wake_cnt == WW'(WAKE_CYC - 1)) state_nx = ST_ACTIVE;
      default:   state_nx = ST_ACTIVE;
    endcase
  end

  assign mem_ls = (state == ST_SLEEP);
`else
  state_t state;
  logic   cfg_unused;

  // Without light sleep the controller never leaves ACTIVE; the sleep
  // timing parameters have no consumer in this build.
  assign state      = ST_ACTIVE;
  assign mem_ls     = 1'b0;
  assign cfg_unused = ^{IDLE_CYC, WAKE_CYC};
`endif

  assign active  = (state == ST_ACTIVE);
  assign in_rdy  = ~rst & (mcnt < NW) & ~flush & active;
  assign wr      = in_vld & in_rdy;
  assign iss     = iss_ok & active & ~flush;

  assign mem_mea   = wr;
  assign mem_rwa   = 1'b1;
  assign mem_wadra = wp;
  assign mem_da    = in_dat;
  assign mem_wma   = '0;
  assign mem_meb   = iss;
  assign mem_radrb = rp;
  assign mem_radra = '0;
  assign mem_wadrb = '0;
  assign mem_db    = '0;
  assign mem_rwb   = 1'b0;
  assign mem_wmb   = '1;
  assign mem_ds    = 1'b0;
  assign mem_sd    = 1'b0;

  assign out_vld = (skc != 2'd0);
  assign out_dat = sk0;
  assign level   = {1'b0, mcnt} + {{(AW+1){1'b0}}, inf} + {{AW{1'b0}}, skc};

  // Memory-side bookkeeping: pointers, stored-word count and in-flight read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp   <= '0;
      rp   <= '0;
      mcnt <= '0;
      inf  <= 1'b0;
    end else if (flush) begin
      wp   <= '0;
      rp   <= '0;
      mcnt <= '0;
      inf  <= 1'b0;
    end else begin
      if (wr)  wp <= wp + 1'b1;
      if (iss) rp <= rp + 1'b1;
      case ({wr, iss})
        2'b10:   mcnt <= mcnt + 1'b1;
        2'b01:   mcnt <= mcnt - 1'b1;
        default: mcnt <= mcnt;
      endcase
      inf <= iss;
    end
  end

  // Output skid: pop shifts the head out, a returning read fills the tail.
  // Flush drops the in-flight word by clearing inf alongside skc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sk0 <= '0;
      sk1 <= '0;
      skc <= 2'd0;
    end else if (flush) begin
      skc <= 2'd0;
    end else begin
      skc <= skc_pop + {1'b0, inf};
      if (pop) sk0 <= sk1;
      if (inf) begin
        if (skc_pop == 2'd0) sk0 <= mem_qb;
        else                 sk1 <= mem_qb;
      end
    end
  end

endmodule

// File: tb/tb_mem2p_fifo_ctrl.sv
// tb/tb_mem2p_fifo_ctrl.sv - self-checking bench for mem2p_fifo_ctrl with behavioural memories and FIFO model
module tb_mem2p_fifo_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // stimulus, index 0 = AW=5 instance, index 1 = AW=2 instance
  logic       fl  [2];
  logic       iv  [2];
  logic       orr [2];
  logic [7:0] id  [2];

  logic       in_rdy0, out_vld0, mea0, rwa0, meb0, rwb0, ls0, ds0, sd0;
  logic [7:0] out_dat0, da0, wma0, db0, wmb0, qb0;
  logic [6:0] level0;
  logic [4:0] wadra0, radrb0, radra0, wadrb0;

  logic       in_rdy1, out_vld1, mea1, rwa1, meb1, rwb1, ls1, ds1, sd1;
  logic [7:0] out_dat1, da1, wma1, db1, wmb1, qb1;
  logic [3:0] level1;
  logic [1:0] wadra1, radrb1, radra1, wadrb1;

  mem2p_fifo_ctrl #(.AW(5), .DW(8), .IDLE_CYC(16), .WAKE_CYC(2)) u_dut0 (
    .clk(clk), .rst(rst), .flush(fl[0]), .in_vld(iv[0]), .in_dat(id[0]), .in_rdy(in_rdy0),
    .out_vld(out_vld0), .out_dat(out_dat0), .out_rdy(orr[0]), .level(level0),
    .mem_mea(mea0), .mem_rwa(rwa0), .mem_wadra(wadra0), .mem_da(da0), .mem_wma(wma0),
    .mem_meb(meb0), .mem_radrb(radrb0), .mem_qb(qb0), .mem_radra(radra0), .mem_wadrb(wadrb0),
    .mem_db(db0), .mem_rwb(rwb0), .mem_wmb(wmb0), .mem_ls(ls0), .mem_ds(ds0), .mem_sd(sd0)
  );

  mem2p_fifo_ctrl #(.AW(2), .DW(8), .IDLE_CYC(16), .WAKE_CYC(2)) u_dut1 (
    .clk(clk), .rst(rst), .flush(fl[1]), .in_vld(iv[1]), .in_dat(id[1]), .in_rdy(in_rdy1),
    .out_vld(out_vld1), .out_dat(out_dat1), .out_rdy(orr[1]), .level(level1),
    .mem_mea(mea1), .mem_rwa(rwa1), .mem_wadra(wadra1), .mem_da(da1), .mem_wma(wma1),
    .mem_meb(meb1), .mem_radrb(radrb1), .mem_qb(qb1), .mem_radra(radra1), .mem_wadrb(wadrb1),
    .mem_db(db1), .mem_rwb(rwb1), .mem_wmb(wmb1), .mem_ls(ls1), .mem_ds(ds1), .mem_sd(sd1)
  );

  // behavioural two-port memories: registered read, masked write
  logic [7:0] mem0 [32];
  logic [7:0] mem1 [4];
  always @(posedge clk) begin
    if (mea0 && rwa0 && !ls0) mem0[wadra0] <= (da0 & ~wma0) | (mem0[wadra0] & wma0);
    if (meb0 && !rwb0 && !ls0) qb0 <= mem0[radrb0];
    if (mea1 && rwa1 && !ls1) mem1[wadra1] <= (da1 & ~wma1) | (mem1[wadra1] & wma1);
    if (meb1 && !rwb1 && !ls1) qb1 <= mem1[radrb1];
  end

  // uniform views of both instances
  logic       ir [2], ov [2], mea [2], meb [2];
  logic [7:0] od [2];
  logic [6:0] lv [2];
  logic [4:0] wa [2], ra [2];
  assign ir[0] = in_rdy0;  assign ir[1] = in_rdy1;
  assign ov[0] = out_vld0; assign ov[1] = out_vld1;
  assign od[0] = out_dat0; assign od[1] = out_dat1;
  assign mea[0] = mea0;    assign mea[1] = mea1;
  assign meb[0] = meb0;    assign meb[1] = meb1;
  assign lv[0] = level0;   assign lv[1] = {3'b000, level1};
  assign wa[0] = wadra0;   assign wa[1] = {3'b000, wadra1};
  assign ra[0] = radrb0;   assign ra[1] = {3'b000, radrb1};

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // model: word counts accepted / read from memory / delivered since flush
  int         wcnt [2], rcnt [2], dcnt [2], got [2];
  logic       inf_m [2];
  logic [7:0] sb [2][128];
  int         wseq [8];
  int         wn = 0;

  always @(negedge clk) begin
    int   nw;
    logic e_ir, e_ov, e_iss, pop, acc, iss;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        wcnt[k] = 0; rcnt[k] = 0; dcnt[k] = 0; got[k] = 0; inf_m[k] = 1'b0;
      end else begin
        nw    = (k == 0) ? 32 : 4;
        e_ir  = ((wcnt[k] - rcnt[k]) < nw) && !fl[k];
        e_ov  = (rcnt[k] - dcnt[k] - int'(inf_m[k])) > 0;
        pop   = e_ov && orr[k];
        e_iss = ((wcnt[k] - rcnt[k]) > 0) && ((rcnt[k] - dcnt[k] - int'(pop)) < 2) && !fl[k];
        chk($sformatf("level%0d", k), int'(lv[k]), wcnt[k] - dcnt[k]);
        chk($sformatf("out_vld%0d", k), int'(ov[k]), int'(e_ov));
        if (e_ov) chk($sformatf("out_dat%0d", k), int'(od[k]), int'(sb[k][dcnt[k] % 128]));
`ifdef MEM2P_FIFO_LS_EN
        acc = iv[k] && ir[k];
        iss = meb[k];
        chk($sformatf("in_rdy_bound%0d", k), int'(ir[k] && !e_ir), 0);
        chk($sformatf("issue_bound%0d", k), int'(meb[k] && !e_iss), 0);
`else
        acc = iv[k] && e_ir;
        iss = e_iss;
        chk($sformatf("in_rdy%0d", k), int'(ir[k]), int'(e_ir));
        chk($sformatf("mem_meb%0d", k), int'(meb[k]), int'(iss));
`endif
        chk($sformatf("mem_mea%0d", k), int'(mea[k]), int'(acc));
        if (acc) chk($sformatf("wadra%0d", k), int'(wa[k]), wcnt[k] % nw);
        if (iss) chk($sformatf("radrb%0d", k), int'(ra[k]), rcnt[k] % nw);
        if (fl[k]) begin
          wcnt[k] = 0; rcnt[k] = 0; dcnt[k] = 0; inf_m[k] = 1'b0;
        end else begin
          if (acc) begin
            sb[k][wcnt[k] % 128] = id[k];
            if (k == 1 && wn < 8) begin
              wseq[wn] = int'(wa[1]);
              wn++;
            end
            wcnt[k]++;
          end
          if (iss) rcnt[k]++;
          if (pop) begin
            dcnt[k]++;
            got[k]++;
          end
          inf_m[k] = iss;
        end
      end
    end
  end

  task automatic push(input int k, input logic [7:0] d);
    int n;
    iv[k] = 1'b1;
    id[k] = d;
    n = 0;
    @(negedge clk);
    while (!ir[k] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ir[k]) chk("push_timeout", 0, 1);
    @(posedge clk);
    #1;
    iv[k] = 1'b0;
  endtask

  task automatic wait_empty(input int k);
    int n;
    n = 0;
    while (lv[k] != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (lv[k] != 0) chk("drain_timeout", int'(lv[k]), 0);
    @(posedge clk);
    #1;
  endtask

  int   exp_lv [4];
  int   exp_ov [4];
  int   base;
  int   n;
  logic pdone;

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    fl[0] = 1'b0; fl[1] = 1'b0; iv[0] = 1'b1; iv[1] = 1'b0;
    orr[0] = 1'b0; orr[1] = 1'b0; id[0] = 8'h5A; id[1] = 8'h00;
    pdone = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_rdy", int'(in_rdy0), 0);
    chk("rst_out_vld", int'(out_vld0), 0);
    chk("rst_out_dat", int'(out_dat0), 0);
    chk("rst_level", int'(level0), 0);
    chk("rst_mea", int'(mea0), 0);
    chk("rst_meb", int'(meb0), 0);
    chk("rst_ls", int'(ls0), 0);
    chk("rst_ls1", int'(ls1), 0);
    chk("tie_rwa", int'(rwa0), 1);
    chk("tie_wma", int'(wma0), 0);
    chk("tie_wmb", int'(wmb0), 255);
    chk("tie_zero0", int'({radra0, wadrb0, db0, rwb0, ds0, sd0}), 0);
    chk("tie_zero1", int'({radra1, wadrb1, db1, rwb1, ds1, sd1, wma1}), 0);
    chk("tie_one1", int'({rwa1, wmb1}), 511);
    iv[0] = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_rdy", int'(in_rdy0), 1);

    // single word: out_vld 3 cycles after acceptance, level 1,1,1,0
    orr[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b1; id[0] = 8'hA5;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    exp_lv = '{1, 1, 1, 0};
    exp_ov = '{0, 0, 1, 0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("single_level_c%0d", i + 1), int'(level0), exp_lv[i]);
      chk($sformatf("single_vld_c%0d", i + 1), int'(out_vld0), exp_ov[i]);
      if (exp_ov[i] != 0) chk("single_dat", int'(out_dat0), 8'hA5);
    end
    @(posedge clk); #1;

    // fill with consumer stalled: 2 skid + 32 memory
    orr[0] = 1'b0;
    base = got[0];
    for (int i = 0; i < 34; i++) push(0, 8'(i + 16));
    repeat (3) @(negedge clk);
    chk("full_in_rdy", int'(in_rdy0), 0);
    chk("full_level", int'(level0), 34);
    @(posedge clk); #1;
    iv[0] = 1'b1; id[0] = 8'hEE;
    repeat (3) @(negedge clk);
    chk("full_no_accept", int'(level0), 34);
    @(posedge clk); #1;
    iv[0] = 1'b0;
    orr[0] = 1'b1;
    wait_empty(0);
    chk("full_drain_count", got[0] - base, 34);

    // stream 0..99 with consumer toggling every cycle
    base = got[0];
    fork
      begin
        for (int i = 0; i < 100; i++) push(0, 8'(i));
        pdone = 1'b1;
      end
      begin
        for (int c = 0; c < 2000 && !(pdone && lv[0] == 0); c++) begin
          @(posedge clk); #1;
          orr[0] = ~orr[0];
        end
      end
    join
    chk("stream_count", got[0] - base, 100);
    chk("stream_level", int'(level0), 0);

    // flush while a read is in flight
    orr[0] = 1'b0;
    @(posedge clk); #1;
    push(0, 8'h3C);
    @(posedge clk); #1;
    fl[0] = 1'b1;
    @(posedge clk); #1;
    fl[0] = 1'b0;
    @(negedge clk);
    chk("flush_level", int'(level0), 0);
    chk("flush_vld", int'(out_vld0), 0);
    repeat (2) @(negedge clk);
    chk("flush_discard", int'(out_vld0), 0);
    orr[0] = 1'b1;
    @(posedge clk); #1;
    push(0, 8'h11);
    n = 0;
    while (!out_vld0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("flush_next_dat", int'(out_dat0), 8'h11);
    wait_empty(0);

    // flush with skid and memory occupied
    orr[0] = 1'b0;
    for (int i = 0; i < 5; i++) push(0, 8'(i + 200));
    fl[0] = 1'b1;
    @(posedge clk); #1;
    fl[0] = 1'b0;
    @(negedge clk);
    chk("flush_full_level", int'(level0), 0);
    orr[0] = 1'b1;
    @(posedge clk); #1;

    // pointer wrap on the AW=2 instance at full rate
    orr[1] = 1'b1;
    for (int i = 0; i < 100; i++) push(1, 8'(i * 3));
    wait_empty(1);
    chk("wrap_count", got[1], 100);
    for (int j = 0; j < 8; j++) chk($sformatf("wrap_addr%0d", j), wseq[j], j % 4);

`ifdef MEM2P_FIFO_LS_EN
    wait_empty(0);
    repeat (20) @(negedge clk);
    chk("ls_sleep", int'(ls0), 1);
    chk("ls_in_rdy", int'(in_rdy0), 0);
    @(posedge clk); #1;
    iv[0] = 1'b1; id[0] = 8'h77;
    @(negedge clk);
    chk("ls_req_rdy", int'(in_rdy0), 0);
    @(negedge clk);
    chk("ls_wake_ls", int'(ls0), 0);
    chk("ls_wake0_rdy", int'(in_rdy0), 0);
    @(negedge clk);
    chk("ls_wake1_rdy", int'(in_rdy0), 0);
    @(negedge clk);
    chk("ls_active_rdy", int'(in_rdy0), 1);
    @(posedge clk); #1;
    iv[0] = 1'b0;
    wait_empty(0);
`endif

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
